// File: rtl/mem_port_arbiter.sv
// mem_port_arbiter: one single-ported memory shared by IF fetch and MEM load/store; MEM wins, a starvation guard bounds IF blocking.
// Latency: request seen in IDLE at cycle N -> one-cycle ready pulse at N+WAIT_CYCLES+1; one access in flight, no back-to-back grants.
// Backpressure: requesters hold their request until ready; stall_if/stall_mem freeze ID. MEM_ARB_STATS_EN adds saturating grant/conflict counters.
module mem_port_arbiter #(
    parameter int ADDR_W      = 32,
    parameter int DATA_W      = 32,
    parameter int WAIT_CYCLES = 2,
    parameter int STARVE_MAX  = 4
) (
    input  logic              clock,
    input  logic              reset,
    input  logic              if_req,
    input  logic [ADDR_W-1:0] if_addr,
    output logic [DATA_W-1:0] if_rdata,
    output logic              if_ready,
    input  logic              mem_read,
    input  logic              mem_write,
    input  logic [ADDR_W-1:0] mem_addr,
    input  logic [DATA_W-1:0] mem_wdata,
    output logic [DATA_W-1:0] mem_rdata,
    output logic              mem_ready,
    output logic              ram_en,
    output logic              ram_we,
    output logic [ADDR_W-1:0] ram_addr,
    output logic [DATA_W-1:0] ram_wdata,
    input  logic [DATA_W-1:0] ram_rdata,
    output logic              stall_if,
    output logic              stall_mem,
    output logic              busy
`ifdef MEM_ARB_STATS_EN
    ,
    output logic [15:0]       stat_if_grants,
    output logic [15:0]       stat_mem_grants,
    output logic [15:0]       stat_conflicts
`endif
);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ACCESS = 2'd1,
        RESP   = 2'd2
    } state_t;

    localparam logic [3:0] CNT_INIT   = 4'(WAIT_CYCLES - 1);
    localparam logic [3:0] STARVE_LIM = 4'(STARVE_MAX);

    state_t     state;
    state_t     state_nxt;
    logic [3:0] cnt;
    logic [3:0] starve;
    logic       owner_mem;
    logic       rd_clr;
    logic       mem_req;
    logic       grant_mem;
    logic       grant_if;

    assign mem_req   = mem_read | mem_write;
    assign stall_if  = if_req & ~if_ready;
    assign stall_mem = mem_req & ~mem_ready;
    assign busy      = (state != IDLE);

    always_ff @(posedge clock) begin
        if (!reset) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // IF only overrides MEM once it has lost STARVE_MAX arbitrations in a row.
    always_comb begin
        state_nxt = state;
        grant_mem = 1'b0;
        grant_if  = 1'b0;
        case (state)
            IDLE: begin
                if (mem_req && !(if_req && starve == STARVE_LIM)) begin
                    grant_mem = 1'b1;
                end else if (if_req) begin
                    grant_if = 1'b1;
                end
                if (grant_mem || grant_if) begin
                    state_nxt = ACCESS;
                end
            end
            ACCESS: begin
                if (cnt == 4'd0) begin
                    state_nxt = RESP;
                end
            end
            RESP: begin
                state_nxt = IDLE;
            end
            default: begin
                state_nxt = IDLE;
            end
        endcase
    end

    always_ff @(posedge clock) begin
        if (!reset) begin
            cnt       <= 4'd0;
            starve    <= 4'd0;
            owner_mem <= 1'b0;
            rd_clr    <= 1'b0;
            ram_en    <= 1'b0;
            ram_we    <= 1'b0;
            ram_addr  <= '0;
            ram_wdata <= '0;
            if_rdata  <= '0;
            mem_rdata <= '0;
            if_ready  <= 1'b0;
            mem_ready <= 1'b0;
        end else begin
            if_ready  <= 1'b0;
            mem_ready <= 1'b0;
            case (state)
                IDLE: begin
                    if (grant_mem || grant_if) begin
                        owner_mem <= grant_mem;
                        cnt       <= CNT_INIT;
                        ram_en    <= 1'b1;
                        ram_we    <= grant_mem & mem_write;
                        ram_addr  <= grant_mem ? mem_addr : if_addr;
                        ram_wdata <= grant_mem ? mem_wdata : '0;
                        rd_clr    <= grant_mem & mem_read & mem_write;
                    end
                    if (if_req && grant_mem) begin
                        if (starve != STARVE_LIM) begin
                            starve <= starve + 4'd1;
                        end
                    end else begin
                        starve <= 4'd0;
                    end
                end
                ACCESS: begin
                    if (cnt != 4'd0) begin
                        cnt <= cnt - 4'd1;
                    end else begin
                        ram_en <= 1'b0;
                        ram_we <= 1'b0;
                        if (owner_mem) begin
                            mem_ready <= 1'b1;
                            // A combined read+write is a store whose load result reads as zero.
                            if (rd_clr) begin
                                mem_rdata <= '0;
                            end else if (!ram_we) begin
                                mem_rdata <= ram_rdata;
                            end
                        end else begin
                            if_ready <= 1'b1;
                            if_rdata <= ram_rdata;
                        end
                    end
                end
                default: begin
                end
            endcase
        end
    end

`ifdef MEM_ARB_STATS_EN
    always_ff @(posedge clock) begin
        if (!reset) begin
            stat_if_grants  <= 16'd0;
            stat_mem_grants <= 16'd0;
            stat_conflicts  <= 16'd0;
        end else if (state == IDLE) begin
            if (grant_if && stat_if_grants != 16'hFFFF) begin
                stat_if_grants <= stat_if_grants + 16'd1;
            end
            if (grant_mem && stat_mem_grants != 16'hFFFF) begin
                stat_mem_grants <= stat_mem_grants + 16'd1;
            end
            if (if_req && mem_req && stat_conflicts != 16'hFFFF) begin
                stat_conflicts <= stat_conflicts + 16'd1;
            end
        end
    end
`endif

endmodule
